// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR fault monitor: health states,
// channel indices, majority and popcount functions.
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_FAILED   = 2'd2
  } health_t;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/tmr_dissent_cnt.sv
// One saturating consecutive-dissent counter; reach flags that the
// post-update count is at or above THRESH.
module tmr_dissent_cnt #(
  parameter int THRESH = 4,
  parameter int CNT_W  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic valid,
  input  logic dis,
  output logic reach
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Any agreeing valid sample breaks the run; idle cycles leave it alone.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (valid) begin
      if (!dis)                  cnt_next = '0;
      else if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
    end
  end

  assign reach = (cnt_next >= THRESH_V);

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Checks an upstream TMR voter: per-channel dissent tracking, sticky faults,
// health FSM and voter cross-check. TMR_ERR_CLEAR_EN adds the err_clr port.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef TMR_ERR_CLEAR_EN
  input  logic       err_clr,
`endif
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       y,
  output logic       y_q,
  output logic       y_q_valid,
  output logic [2:0] dissent,
  output logic [2:0] faulty,
  output logic [1:0] state,
  output logic       voter_err
);

  logic       clr;
  logic       m;
  logic [2:0] ch;
  logic [2:0] dissent_next;
  logic [2:0] reach;
  logic [2:0] faulty_next;
  logic [1:0] nfault;

  logic       y_q_reg;
  logic       y_q_valid_reg;
  logic [2:0] dissent_reg;
  logic [2:0] faulty_reg;
  logic       voter_err_reg;
  health_t    state_reg;
  health_t    state_next;

`ifdef TMR_ERR_CLEAR_EN
  assign clr = err_clr;
`else
  assign clr = 1'b0;
`endif

  assign m  = maj3(a, b, c);
  assign ch = {c, b, a};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      assign dissent_next[gi] = in_valid & (ch[gi] != m);

      tmr_dissent_cnt #(
        .THRESH (THRESH),
        .CNT_W  (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .valid (in_valid),
        .dis   (dissent_next[gi]),
        .reach (reach[gi])
      );
    end
  endgenerate

  assign faulty_next = clr ? 3'b000 : (faulty_reg | reach);
  assign nfault      = popcount3(faulty_next);

  always_comb begin
    state_next = state_reg;
    if (clr) begin
      state_next = ST_OK;
    end else begin
      case (state_reg)
        ST_OK: begin
          if (nfault >= 2'd2)      state_next = ST_FAILED;
          else if (nfault == 2'd1) state_next = ST_DEGRADED;
        end
        ST_DEGRADED: begin
          if (nfault >= 2'd2) state_next = ST_FAILED;
        end
        ST_FAILED: state_next = ST_FAILED;
        default:   state_next = ST_OK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_reg       <= 1'b0;
      y_q_valid_reg <= 1'b0;
      dissent_reg   <= 3'b000;
      faulty_reg    <= 3'b000;
      voter_err_reg <= 1'b0;
      state_reg     <= ST_OK;
    end else begin
      y_q_valid_reg <= in_valid;
      dissent_reg   <= dissent_next;
      faulty_reg    <= faulty_next;
      state_reg     <= state_next;
      // Output is forced low once the triple can no longer be trusted.
      if (in_valid) y_q_reg <= (state_reg == ST_FAILED) ? 1'b0 : m;
      if (clr)      voter_err_reg <= 1'b0;
      else if (in_valid && (y != m)) voter_err_reg <= 1'b1;
    end
  end

  assign y_q       = y_q_reg;
  assign y_q_valid = y_q_valid_reg;
  assign dissent   = dissent_reg;
  assign faulty    = faulty_reg;
  assign state     = state_reg;
  assign voter_err = voter_err_reg;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed scoreboard bench for tmr_fault_monitor; clear tests run only
// when TMR_ERR_CLEAR_EN is defined.
module tb_tmr_fault_monitor;
  import tmr_pkg::*;

  typedef struct {
    int         id;
    logic       yq;
    logic       vld;
    logic [2:0] dis;
    logic [2:0] flt;
    logic [1:0] st;
    logic       verr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, y = 1'b0;
  logic       y_q, y_q_valid, voter_err;
  logic [2:0] dissent, faulty;
  logic [1:0] state;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  always #5 clk = ~clk;

  tmr_fault_monitor #(.THRESH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef TMR_ERR_CLEAR_EN
    .err_clr   (err_clr),
`endif
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .y         (y),
    .y_q       (y_q),
    .y_q_valid (y_q_valid),
    .dissent   (dissent),
    .faulty    (faulty),
    .state     (state),
    .voter_err (voter_err)
  );

  // Monitor: every cycle's outputs are compared against the record queued
  // by the stimulus on the preceding falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (y_q === e.yq && y_q_valid === e.vld && dissent === e.dis &&
            faulty === e.flt && state === e.st && voter_err === e.verr) begin
          n_pass++;
          $display("step %0d ok: y_q=%b vld=%b dis=%b flt=%b st=%0d verr=%b",
                   e.id, y_q, y_q_valid, dissent, faulty, state, voter_err);
        end else begin
          $display("FAIL step%0d: got y_q=%b vld=%b dis=%b flt=%b st=%0d verr=%b, want y_q=%b vld=%b dis=%b flt=%b st=%0d verr=%b",
                   e.id, y_q, y_q_valid, dissent, faulty, state, voter_err,
                   e.yq, e.vld, e.dis, e.flt, e.st, e.verr);
        end
      end
    end
  end

  // Drive one sample and queue the outputs it must produce one cycle later.
  task automatic step(input logic r, input logic cl, input logic v,
                      input logic ia, input logic ib, input logic ic, input logic iy,
                      input logic eyq, input logic evld, input logic [2:0] edis,
                      input logic [2:0] eflt, input logic [1:0] est, input logic everr);
    exp_t e;
    @(negedge clk);
    rst = r; err_clr = cl; in_valid = v;
    a = ia; b = ib; c = ic; y = iy;
    step_id++;
    e.id = step_id; e.yq = eyq; e.vld = evld; e.dis = edis;
    e.flt = eflt; e.st = est; e.verr = everr;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset
    step(1,0,0, 0,0,0,0,  0,0,3'b000,3'b000,2'd0,0);
    step(1,0,1, 1,1,1,1,  0,0,3'b000,3'b000,2'd0,0);
    // All eight a/b/c patterns, voter correct
    step(0,0,1, 0,0,0,0,  0,1,3'b000,3'b000,2'd0,0);
    step(0,0,1, 1,0,0,0,  0,1,3'b001,3'b000,2'd0,0);
    step(0,0,1, 0,1,0,0,  0,1,3'b010,3'b000,2'd0,0);
    step(0,0,1, 1,1,0,1,  1,1,3'b100,3'b000,2'd0,0);
    step(0,0,1, 0,0,1,0,  0,1,3'b100,3'b000,2'd0,0);
    step(0,0,1, 1,0,1,1,  1,1,3'b010,3'b000,2'd0,0);
    step(0,0,1, 0,1,1,1,  1,1,3'b001,3'b000,2'd0,0);
    step(0,0,1, 1,1,1,1,  1,1,3'b000,3'b000,2'd0,0);
    // Three dissents on a then an agree: no fault
    for (int i = 0; i < 3; i++)
      step(0,0,1, 1,0,0,0,  0,1,3'b001,3'b000,2'd0,0);
    step(0,0,1, 0,0,0,0,  0,1,3'b000,3'b000,2'd0,0);
    // Four consecutive dissents on a: fault visible after the 4th
    for (int i = 0; i < 3; i++)
      step(0,0,1, 1,0,0,0,  0,1,3'b001,3'b000,2'd0,0);
    step(0,0,1, 1,0,0,0,  0,1,3'b001,3'b001,2'd1,0);
    // Voter disagrees with majority once: sticky, state untouched
    step(0,0,1, 1,1,0,0,  1,1,3'b100,3'b001,2'd1,1);
    step(0,0,1, 0,0,0,0,  0,1,3'b000,3'b001,2'd1,1);
    // b dissents four times: second fault -> FAILED
    for (int i = 0; i < 3; i++)
      step(0,0,1, 0,1,0,0,  0,1,3'b010,3'b001,2'd1,1);
    step(0,0,1, 0,1,0,0,  0,1,3'b010,3'b011,2'd2,1);
    step(0,0,1, 1,1,1,1,  0,1,3'b000,3'b011,2'd2,1);
    step(0,0,1, 1,1,0,1,  0,1,3'b100,3'b011,2'd2,1);
    step(0,0,0, 1,1,1,1,  0,0,3'b000,3'b011,2'd2,1);
`ifdef TMR_ERR_CLEAR_EN
    // Clear from FAILED, then clear coinciding with a dissenting sample
    step(0,1,0, 1,1,1,1,  0,0,3'b000,3'b000,2'd0,0);
    step(0,0,1, 1,1,1,1,  1,1,3'b000,3'b000,2'd0,0);
    for (int i = 0; i < 3; i++)
      step(0,0,1, 0,1,1,1,  1,1,3'b001,3'b000,2'd0,0);
    step(0,1,1, 0,1,1,0,  1,1,3'b001,3'b000,2'd0,0);
    step(0,0,1, 0,1,1,1,  1,1,3'b001,3'b000,2'd0,0);
`endif
    // Reset mid-run with a valid sample present: sample discarded
    step(1,0,1, 1,1,1,1,  0,0,3'b000,3'b000,2'd0,0);
    // Dissent run of 2, 5-cycle gap, then 2 more: fault on the 4th
    step(0,0,1, 0,1,1,1,  1,1,3'b001,3'b000,2'd0,0);
    step(0,0,1, 0,1,1,1,  1,1,3'b001,3'b000,2'd0,0);
    for (int i = 0; i < 5; i++)
      step(0,0,0, 0,0,0,0,  1,0,3'b000,3'b000,2'd0,0);
    step(0,0,1, 0,1,1,1,  1,1,3'b001,3'b000,2'd0,0);
    step(0,0,1, 0,1,1,1,  1,1,3'b001,3'b001,2'd1,0);
    step(0,0,1, 1,1,1,1,  1,1,3'b000,3'b001,2'd1,0);
    step(1,0,0, 0,0,0,0,  0,0,3'b000,3'b000,2'd0,0);

    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
